// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg : shared constants and target state encoding.    Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package i2c_pkg;

  localparam logic [6:0] DEFAULT_ADDR = 7'h50;
  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_PTR       = 4'd3;
  localparam logic [3:0] ST_PTR_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RDATA_ACK = 4'd8;
  localparam logic [3:0] ST_IGNORE    = 4'd9;

  typedef enum logic [3:0] {
    TS_IDLE      = ST_IDLE,
    TS_ADDR      = ST_ADDR,
    TS_ADDR_ACK  = ST_ADDR_ACK,
    TS_PTR       = ST_PTR,
    TS_PTR_ACK   = ST_PTR_ACK,
    TS_WDATA     = ST_WDATA,
    TS_WDATA_ACK = ST_WDATA_ACK,
    TS_RDATA     = ST_RDATA,
    TS_RDATA_ACK = ST_RDATA_ACK,
    TS_IGNORE    = ST_IGNORE
  } tgt_state_e;

endpackage

`default_nettype wire

// File: rtl/i2c_target_if.sv
// ---------------------------------------------------------------------------
// i2c_target_if : I2C pad-side signals of the target.      Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface i2c_target_if;
  logic scl_i;
  logic sda_i;
  logic sda_o;
  logic scl_o;

  modport slave  (input  scl_i, input  sda_i, output sda_o, output scl_o);
  modport master (output scl_i, output sda_i, input  sda_o, input  scl_o);
endinterface

`default_nettype wire

// File: rtl/i2c_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync : SCL/SDA synchronizer and edge/START/STOP detector. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic sda_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  // Idle bus level is high, so reset to 1 to avoid spurious events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // START/STOP qualify on the previous SCL level: a simultaneous SDA/SCL
  // change is then seen as SDA moving first.
  assign scl_rise_o  =  scl_s & ~scl_prev_q;
  assign scl_fall_o  = ~scl_s &  scl_prev_q;
  assign start_det_o =  scl_prev_q &  sda_prev_q & ~sda_s;
  assign stop_det_o  =  scl_prev_q & ~sda_prev_q &  sda_s;
  assign sda_o       =  sda_s;

endmodule

`default_nettype wire

// File: rtl/i2c_target.sv
// ---------------------------------------------------------------------------
// i2c_target : I2C target with auto-incrementing register bank.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEFAULT_ADDR,
  parameter int         DEPTH       = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        PW          = $clog2(DEPTH)
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  i2c_target_if.slave   bus,
  output logic          busy,
  output logic          wr_valid,
  output logic [PW-1:0] wr_ptr,
  output logic [7:0]    wr_data,
  output logic [PW-1:0] rd_ptr
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (PCLK),
    .rst_n       (PRESETn),
    .scl_i       (bus.scl_i),
    .sda_i       (bus.sda_i),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det),
    .sda_o       (sda_s)
  );

  tgt_state_e    state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          sda_q, sda_d;
  logic          busy_q, busy_d;
  logic          ack_on_q, ack_on_d;
  logic          rw_q, rw_d;
  logic          load_q, load_d;
  logic          wr_valid_q, wr_valid_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    byte_in;
  logic          last_bit;

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    ptr_d      = ptr_q;
    sda_d      = sda_q;
    busy_d     = busy_q;
    ack_on_d   = ack_on_q;
    rw_d       = rw_q;
    load_d     = load_q;
    wr_valid_d = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    wr_data_d  = wr_data_q;
    byte_in    = {shreg_q[6:0], sda_s};
    last_bit   = (bitcnt_q == 3'd7);

    if (stop_det) begin
      state_d  = TS_IDLE;
      sda_d    = NACK;
      busy_d   = 1'b0;
      ack_on_d = 1'b0;
      load_d   = 1'b0;
    end else if (start_det) begin
      state_d  = TS_ADDR;
      bitcnt_d = 3'd0;
      sda_d    = NACK;
      busy_d   = 1'b1;
      ack_on_d = 1'b0;
      load_d   = 1'b0;
    end else begin
      case (state_q)
        TS_ADDR, TS_PTR, TS_WDATA: begin
          if (scl_rise) begin
            shreg_d  = byte_in;
            bitcnt_d = bitcnt_q + 3'd1;
            if (last_bit) begin
              if (state_q == TS_ADDR) begin
                rw_d    = byte_in[0];
                state_d = (byte_in[7:1] == DEV_ADDR) ? TS_ADDR_ACK : TS_IGNORE;
              end else if (state_q == TS_PTR) begin
                ptr_d   = byte_in[PW-1:0];
                state_d = TS_PTR_ACK;
              end else begin
                wr_valid_d = 1'b1;
                wr_ptr_d   = ptr_q;
                wr_data_d  = byte_in;
                ptr_d      = ptr_q + 1'b1;
                state_d    = TS_WDATA_ACK;
              end
            end
          end
        end
        // First SCL fall pulls SDA low, the second one ends the ACK slot.
        TS_ADDR_ACK, TS_PTR_ACK, TS_WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              sda_d    = ACK;
              ack_on_d = 1'b1;
            end else begin
              ack_on_d = 1'b0;
              bitcnt_d = 3'd0;
              sda_d    = NACK;
              if (state_q == TS_ADDR_ACK && rw_q) begin
                state_d = TS_RDATA;
                sda_d   = mem_q[ptr_q][7];
                shreg_d = {mem_q[ptr_q][6:0], 1'b0};
              end else if (state_q == TS_ADDR_ACK) begin
                state_d = TS_PTR;
              end else begin
                state_d = TS_WDATA;
              end
            end
          end
        end
        TS_RDATA: begin
          if (scl_fall) begin
            if (load_q) begin
              load_d   = 1'b0;
              bitcnt_d = 3'd0;
              sda_d    = mem_q[ptr_q][7];
              shreg_d  = {mem_q[ptr_q][6:0], 1'b0};
            end else if (last_bit) begin
              sda_d    = NACK;
              bitcnt_d = 3'd0;
              ptr_d    = ptr_q + 1'b1;
              state_d  = TS_RDATA_ACK;
            end else begin
              sda_d    = shreg_q[7];
              shreg_d  = {shreg_q[6:0], 1'b0};
              bitcnt_d = bitcnt_q + 3'd1;
            end
          end
        end
        TS_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s == ACK) begin
              state_d = TS_RDATA;
              load_d  = 1'b1;
            end else begin
              state_d = TS_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= TS_IDLE;
      bitcnt_q   <= 3'd0;
      shreg_q    <= 8'd0;
      ptr_q      <= '0;
      sda_q      <= 1'b1;
      busy_q     <= 1'b0;
      ack_on_q   <= 1'b0;
      rw_q       <= 1'b0;
      load_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      wr_data_q  <= 8'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'd0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      ptr_q      <= ptr_d;
      sda_q      <= sda_d;
      busy_q     <= busy_d;
      ack_on_q   <= ack_on_d;
      rw_q       <= rw_d;
      load_q     <= load_d;
      wr_valid_q <= wr_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_data_q  <= wr_data_d;
      if (wr_valid_d) mem_q[wr_ptr_d] <= wr_data_d;
    end
  end

  assign bus.sda_o = sda_q;
  assign bus.scl_o = 1'b1;
  assign busy      = busy_q;
  assign wr_valid  = wr_valid_q;
  assign wr_ptr    = wr_ptr_q;
  assign wr_data   = wr_data_q;
  assign rd_ptr    = ptr_q;

endmodule

`default_nettype wire
